// File: rtl/cajero_param.sv
// -----------------------------------------------------------------------------
// cajero_param -- ATM transaction controller.
//
// A card session runs IDLE -> PIN -> VERIFICAR -> MONTO -> FIN. The PIN is
// collected one BCD digit at a time and compared against PIN_CORRECTO.
// Wrong PINs are counted; the last allowed try raises ADVERTENCIA, and the
// try after that locks the card (BLOQUEADO). A deposit saturates at the
// full-scale balance. A withdrawal larger than the balance is refused.
//
// Optional feature, selected by the macro CAJERO_DESBLOQUEO_EN: the lockout
// clears itself after TIMEOUT_CYCLES cycles. Without the macro, only reset
// leaves BLOQUEADO.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-low reset
//   TARJETA_RECIBIDA         card present (level)
//   DIGITO_STB / DIGITO      PIN digit strobe and BCD digit
//   PIN_CORRECTO             expected PIN, first digit in the MS nibble
//   MONTO_STB / MONTO        amount strobe and amount
//   TIPO_TRANS               0 = deposit, 1 = withdrawal (sampled with MONTO_STB)
//   BALANCE_INICIAL          balance before the transaction
//   BALANCE_ACTUALIZADO      resulting balance, held until the next update
//   BALANCE_STB, ENTREGAR_DINERO, PIN_INCORRECTO, FONDOS_INSUFICIENTES
//                            one-cycle pulses
//   ADVERTENCIA, BLOQUEO     levels
// -----------------------------------------------------------------------------
module cajero_param #(
    parameter int N_DIGITS       = 4,
    parameter int BAL_W          = 64,
    parameter int MAX_INTENTOS   = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  TARJETA_RECIBIDA,
    input  logic                  TIPO_TRANS,
    input  logic                  DIGITO_STB,
    input  logic [3:0]            DIGITO,
    input  logic [4*N_DIGITS-1:0] PIN_CORRECTO,
    input  logic                  MONTO_STB,
    input  logic [BAL_W-1:0]      MONTO,
    input  logic [BAL_W-1:0]      BALANCE_INICIAL,
    output logic [BAL_W-1:0]      BALANCE_ACTUALIZADO,
    output logic                  BALANCE_STB,
    output logic                  ENTREGAR_DINERO,
    output logic                  PIN_INCORRECTO,
    output logic                  ADVERTENCIA,
    output logic                  BLOQUEO,
    output logic                  FONDOS_INSUFICIENTES
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam int FW    = $clog2(MAX_INTENTOS + 1);

    // Reject configurations that the counters cannot represent.
    generate
        if (N_DIGITS < 1 || N_DIGITS > 8 || MAX_INTENTOS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("cajero_param: invalid parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_PIN, S_VERIFICAR, S_MONTO, S_FIN, S_BLOQUEADO
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0]   pin_sr_q, pin_sr_d;
    logic [FW-1:0]           fail_q, fail_d;
    logic [BAL_W-1:0]        bal_q, bal_d;
    logic                    bal_stb_q, bal_stb_d;
    logic                    entregar_q, entregar_d;
    logic                    pin_inc_q, pin_inc_d;
    logic                    adv_q, adv_d;
    logic                    bloq_q, bloq_d;
    logic                    fondos_q, fondos_d;
`ifdef CAJERO_DESBLOQUEO_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0]        tmr_q, tmr_d;
`endif

    logic [4*N_DIGITS+3:0]   shifted;
    logic [BAL_W:0]          sum;
    logic [FW-1:0]           fail_inc;

    always_comb begin
        shifted  = {pin_sr_q, DIGITO};
        // Extra MSB catches the carry for deposit saturation.
        sum      = {1'b0, BALANCE_INICIAL} + {1'b0, MONTO};
        fail_inc = fail_q + FW'(1);

        state_d    = state_q;
        cnt_d      = cnt_q;
        pin_sr_d   = pin_sr_q;
        fail_d     = fail_q;
        bal_d      = bal_q;
        adv_d      = adv_q;
        bloq_d     = bloq_q;
        bal_stb_d  = 1'b0;
        entregar_d = 1'b0;
        pin_inc_d  = 1'b0;
        fondos_d   = 1'b0;
`ifdef CAJERO_DESBLOQUEO_EN
        tmr_d      = tmr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (TARJETA_RECIBIDA) begin
                    state_d  = S_PIN;
                    cnt_d    = '0;
                    pin_sr_d = '0;
                end
            end
            S_PIN: begin
                if (!TARJETA_RECIBIDA) begin
                    state_d = S_IDLE;
                end else if (DIGITO_STB) begin
                    pin_sr_d = shifted[4*N_DIGITS-1:0];
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_DIGITS - 1))
                        state_d = S_VERIFICAR;
                end
            end
            S_VERIFICAR: begin
                if (!TARJETA_RECIBIDA) begin
                    state_d = S_IDLE;
                end else if (pin_sr_q == PIN_CORRECTO) begin
                    state_d = S_MONTO;
                    fail_d  = '0;
                    adv_d   = 1'b0;
                end else begin
                    fail_d    = fail_inc;
                    pin_inc_d = 1'b1;
                    cnt_d     = '0;
                    if (fail_inc == FW'(MAX_INTENTOS)) begin
                        state_d = S_BLOQUEADO;
                        bloq_d  = 1'b1;
                        adv_d   = 1'b0;
`ifdef CAJERO_DESBLOQUEO_EN
                        tmr_d   = '0;
`endif
                    end else begin
                        state_d = S_PIN;
                        if (fail_inc == FW'(MAX_INTENTOS - 1))
                            adv_d = 1'b1;
                    end
                end
            end
            S_MONTO: begin
                if (!TARJETA_RECIBIDA) begin
                    state_d = S_IDLE;
                end else if (MONTO_STB) begin
                    state_d = S_FIN;
                    if (!TIPO_TRANS) begin
                        bal_d     = sum[BAL_W] ? '1 : sum[BAL_W-1:0];
                        bal_stb_d = 1'b1;
                    end else if (MONTO <= BALANCE_INICIAL) begin
                        bal_d      = BALANCE_INICIAL - MONTO;
                        bal_stb_d  = 1'b1;
                        entregar_d = 1'b1;
                    end else begin
                        fondos_d = 1'b1;
                    end
                end
            end
            S_FIN: begin
                if (!TARJETA_RECIBIDA)
                    state_d = S_IDLE;
            end
            S_BLOQUEADO: begin
`ifdef CAJERO_DESBLOQUEO_EN
                // BLOQUEO is high for exactly TIMEOUT_CYCLES cycles.
                if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    bloq_d  = 1'b0;
                    fail_d  = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pin_sr_q   <= '0;
            fail_q     <= '0;
            bal_q      <= '0;
            bal_stb_q  <= 1'b0;
            entregar_q <= 1'b0;
            pin_inc_q  <= 1'b0;
            adv_q      <= 1'b0;
            bloq_q     <= 1'b0;
            fondos_q   <= 1'b0;
`ifdef CAJERO_DESBLOQUEO_EN
            tmr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pin_sr_q   <= pin_sr_d;
            fail_q     <= fail_d;
            bal_q      <= bal_d;
            bal_stb_q  <= bal_stb_d;
            entregar_q <= entregar_d;
            pin_inc_q  <= pin_inc_d;
            adv_q      <= adv_d;
            bloq_q     <= bloq_d;
            fondos_q   <= fondos_d;
`ifdef CAJERO_DESBLOQUEO_EN
            tmr_q      <= tmr_d;
`endif
        end
    end

    assign BALANCE_ACTUALIZADO  = bal_q;
    assign BALANCE_STB          = bal_stb_q;
    assign ENTREGAR_DINERO      = entregar_q;
    assign PIN_INCORRECTO       = pin_inc_q;
    assign ADVERTENCIA          = adv_q;
    assign BLOQUEO              = bloq_q;
    assign FONDOS_INSUFICIENTES = fondos_q;

endmodule

// File: tb/tb_cajero_param.sv
// -----------------------------------------------------------------------------
// tb_cajero_param -- self-checking bench for cajero_param.
// Two instances share the control inputs: a 64-bit one for the main
// transaction table and an 8-bit one whose amount/balance are fixed at
// 10 / 250, so every deposit it sees saturates at 255.
// -----------------------------------------------------------------------------
module tb_cajero_param;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        card = 1'b0, tipo = 1'b0, dstb = 1'b0, mstb = 1'b0;
    logic [3:0]  digito = '0;
    logic [15:0] pin_ok = 16'h2098;
    logic [63:0] monto = '0, bal_ini = '0;
    logic [7:0]  monto8 = 8'd10, bal_ini8 = 8'd250;

    logic [63:0] bal;
    logic        bstb, entr, pinc, adv, bloq, fond;
    logic [7:0]  bal8;
    logic        bstb8, entr8, pinc8, adv8, bloq8, fond8;

    always #5 clock = ~clock;

    cajero_param #(.N_DIGITS(4), .BAL_W(64), .MAX_INTENTOS(3), .TIMEOUT_CYCLES(20)) dut (
        .clock(clock), .reset(reset), .TARJETA_RECIBIDA(card), .TIPO_TRANS(tipo),
        .DIGITO_STB(dstb), .DIGITO(digito), .PIN_CORRECTO(pin_ok),
        .MONTO_STB(mstb), .MONTO(monto), .BALANCE_INICIAL(bal_ini),
        .BALANCE_ACTUALIZADO(bal), .BALANCE_STB(bstb), .ENTREGAR_DINERO(entr),
        .PIN_INCORRECTO(pinc), .ADVERTENCIA(adv), .BLOQUEO(bloq),
        .FONDOS_INSUFICIENTES(fond));

    cajero_param #(.N_DIGITS(4), .BAL_W(8), .MAX_INTENTOS(3), .TIMEOUT_CYCLES(20)) dut8 (
        .clock(clock), .reset(reset), .TARJETA_RECIBIDA(card), .TIPO_TRANS(tipo),
        .DIGITO_STB(dstb), .DIGITO(digito), .PIN_CORRECTO(pin_ok),
        .MONTO_STB(mstb), .MONTO(monto8), .BALANCE_INICIAL(bal_ini8),
        .BALANCE_ACTUALIZADO(bal8), .BALANCE_STB(bstb8), .ENTREGAR_DINERO(entr8),
        .PIN_INCORRECTO(pinc8), .ADVERTENCIA(adv8), .BLOQUEO(bloq8),
        .FONDOS_INSUFICIENTES(fond8));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Enters four digits then spends the VERIFICAR cycle; on return the
    // verification result is visible on the outputs.
    task automatic enter_pin(input logic [15:0] digs);
        for (int i = 0; i < 4; i++) begin
            digito = digs[15-4*i -: 4];
            dstb   = 1'b1;
            tick();
        end
        dstb = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        tipo;
        logic [63:0] monto;
        logic [63:0] bal_ini;
        logic [63:0] exp_bal;
        logic        exp_stb;
        logic        exp_ent;
        logic        exp_fon;
    } vec_t;

    vec_t vecs[5];
    logic seen_pinc;
    int   k;

    initial begin
        vecs[0] = '{1'b0, 64'd500,  64'd1000, 64'd1500, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 64'd300,  64'd1000, 64'd700,  1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 64'd1200, 64'd1000, 64'd700,  1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 64'd1000, 64'd1000, 64'd0,    1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};

        // Reset state
        tick(); tick();
        chk("rst_outputs", {bal, bstb, entr, pinc, adv, bloq, fond}, '0);
        reset = 1'b1;
        tick();

        // Transaction table
        for (int v = 0; v < 5; v++) begin
            card = 1'b1;
            tick();
            enter_pin(16'h2098);
            chk("verify_no_pin_inc", {63'd0, pinc}, 64'd0);
            tipo    = vecs[v].tipo;
            monto   = vecs[v].monto;
            bal_ini = vecs[v].bal_ini;
            mstb    = 1'b1;
            tick();
            mstb = 1'b0;
            chk($sformatf("v%0d_bal", v), bal, vecs[v].exp_bal);
            chk($sformatf("v%0d_stb", v), {63'd0, bstb}, {63'd0, vecs[v].exp_stb});
            chk($sformatf("v%0d_entregar", v), {63'd0, entr}, {63'd0, vecs[v].exp_ent});
            chk($sformatf("v%0d_fondos", v), {63'd0, fond}, {63'd0, vecs[v].exp_fon});
            chk($sformatf("v%0d_bal8", v), {56'd0, bal8}, vecs[v].tipo ? 64'd240 : 64'd255);
            tick();
            chk($sformatf("v%0d_pulse_end", v), {61'd0, bstb, entr, fond}, 64'd0);
            chk($sformatf("v%0d_bal_held", v), bal, vecs[v].exp_bal);
            card = 1'b0;
            tick();
        end

        // Asynchronous reset in the middle of PIN entry
        card = 1'b1;
        tick();
        digito = 4'd2; dstb = 1'b1; tick();
        digito = 4'd0; tick();
        dstb = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_bal", bal, 64'd0);
        chk("async_rst_bal8", {56'd0, bal8}, 64'd0);
        chk("async_rst_flags", {bstb, entr, pinc, adv, bloq, fond}, '0);
        card = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Fail count survives card removal; correct PIN clears ADVERTENCIA
        card = 1'b1; tick();
        enter_pin(16'h1111);
        chk("ret_pinc1", {63'd0, pinc}, 64'd1);
        chk("ret_adv1", {63'd0, adv}, 64'd0);
        card = 1'b0; tick();
        card = 1'b1; tick();
        enter_pin(16'h1111);
        chk("ret_pinc2", {63'd0, pinc}, 64'd1);
        chk("ret_adv2", {63'd0, adv}, 64'd1);
        enter_pin(16'h2098);
        chk("ret_adv_cleared", {63'd0, adv}, 64'd0);
        card = 1'b0; tick();

        // Three wrong PINs lock the card
        card = 1'b1; tick();
        enter_pin(16'h1111);
        chk("lk_pinc1", {62'd0, pinc, adv}, 64'b10);
        enter_pin(16'h1111);
        chk("lk_pinc2", {62'd0, pinc, adv}, 64'b11);
        enter_pin(16'h1111);
        chk("lk_pinc3", {62'd0, pinc, adv}, 64'b10);
        chk("lk_bloqueo", {63'd0, bloq}, 64'd1);

        // Locked: digits, card removal and amount strobes are ignored
        seen_pinc = 1'b0;
`ifdef CAJERO_DESBLOQUEO_EN
        k = 0;
        for (int c = 1; c <= 200; c++) begin
            dstb   = (c < 10);
            mstb   = (c < 10);
            digito = 4'd1;
            card   = (c > 5);
            tick();
            if (pinc) seen_pinc = 1'b1;
            if (!bloq) begin
                k = c;
                break;
            end
        end
        dstb = 1'b0; mstb = 1'b0;
        chk("unlock_cycles", 64'(k), 64'd20);
        chk("lock_ignores_digits", {63'd0, seen_pinc}, 64'd0);
        chk("unlock_adv", {63'd0, adv}, 64'd0);
`else
        for (int c = 1; c <= 100; c++) begin
            dstb   = (c < 10);
            mstb   = (c < 10);
            digito = 4'd1;
            card   = (c > 5);
            tick();
            if (pinc) seen_pinc = 1'b1;
        end
        dstb = 1'b0; mstb = 1'b0;
        chk("still_locked_100", {63'd0, bloq}, 64'd1);
        chk("lock_ignores_digits", {63'd0, seen_pinc}, 64'd0);
        chk("lock_adv_low", {63'd0, adv}, 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_clears_lock", {63'd0, bloq}, 64'd0);
        reset = 1'b1;
`endif
        card = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cajero_param.md
CAJERO_PARAM -- requirements
Module: cajero_param

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: PIN length in decimal digits (1..8).
REQ-002 SHALL have parameter BAL_W, default 64: balance and amount width.
REQ-003 SHALL have parameter MAX_INTENTOS, default 3: failed PIN tries before lockout (>=2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000: lockout duration (used only under CAJERO_DESBLOQUEO_EN).
REQ-005 SHALL have port clock  in  1  single clock, all state changes on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port TARJETA_RECIBIDA  in  1  card present (level).
REQ-008 SHALL have port TIPO_TRANS  in  1  0=deposit, 1=withdrawal, sampled with MONTO_STB.
REQ-009 SHALL have port DIGITO_STB  in  1  digit valid strobe.
REQ-010 SHALL have port DIGITO  in  4  BCD digit.
REQ-011 SHALL have port PIN_CORRECTO  in  4*N_DIGITS  expected PIN, first digit in MS nibble.
REQ-012 SHALL have port MONTO_STB  in  1  amount valid strobe.
REQ-013 SHALL have port MONTO  in  BAL_W  transaction amount.
REQ-014 SHALL have port BALANCE_INICIAL  in  BAL_W  account balance before transaction.
REQ-015 SHALL have port BALANCE_ACTUALIZADO  out  BAL_W  result balance, held until next update.
REQ-016 SHALL have port BALANCE_STB  out  1  one-cycle pulse, BALANCE_ACTUALIZADO valid.
REQ-017 SHALL have port ENTREGAR_DINERO  out  1  one-cycle pulse, dispense cash.
REQ-018 SHALL have port PIN_INCORRECTO  out  1  one-cycle pulse per wrong PIN.
REQ-019 SHALL have port ADVERTENCIA  out  1  level, fail count == MAX_INTENTOS-1.
REQ-020 SHALL have port BLOQUEO  out  1  level, card locked.
REQ-021 SHALL have port FONDOS_INSUFICIENTES  out  1  one-cycle pulse, withdrawal refused.

Function
REQ-022 SHALL implement states IDLE, PIN, VERIFICAR, MONTO, FIN, BLOQUEADO; all outputs registered.
REQ-023 IDLE: TARJETA_RECIBIDA=1 -> PIN; clear digit counter and PIN shift register.
REQ-024 PIN: each edge with DIGITO_STB=1 shifts DIGITO into LS nibble and increments counter; on edge accepting digit N_DIGITS -> VERIFICAR.
REQ-025 VERIFICAR (exactly one cycle): match -> MONTO, fail counter cleared, ADVERTENCIA cleared.
REQ-026 VERIFICAR mismatch: fail counter +1, PIN_INCORRECTO pulses next cycle, digit counter cleared; count==MAX_INTENTOS-1 sets ADVERTENCIA; count==MAX_INTENTOS -> BLOQUEADO; else -> PIN.
REQ-027 MONTO, MONTO_STB=1, deposit: BALANCE_ACTUALIZADO=BALANCE_INICIAL+MONTO saturated at 2^BAL_W-1; BALANCE_STB pulses next cycle; -> FIN.
REQ-028 MONTO, MONTO_STB=1, withdrawal with MONTO<=BALANCE_INICIAL: BALANCE_ACTUALIZADO=BALANCE_INICIAL-MONTO; BALANCE_STB and ENTREGAR_DINERO pulse together next cycle; -> FIN.
REQ-029 Withdrawal with MONTO>BALANCE_INICIAL: FONDOS_INSUFICIENTES pulses next cycle; BALANCE_ACTUALIZADO unchanged; no BALANCE_STB; -> FIN.
REQ-030 FIN: TARJETA_RECIBIDA=0 -> IDLE.
REQ-031 TARJETA_RECIBIDA=0 in PIN, VERIFICAR or MONTO -> IDLE; fail counter and ADVERTENCIA retained across card removal.
REQ-032 DIGITO_STB ignored outside PIN; MONTO_STB ignored outside MONTO; simultaneous strobes: only the one valid for current state acts.
REQ-033 BLOQUEADO: BLOQUEO=1, ADVERTENCIA=0, all strobes and card ignored.

Reset
REQ-034 reset=0 SHALL asynchronously force IDLE, counters 0, BALANCE_ACTUALIZADO=0, all 1-bit outputs 0, including mid-transaction and in BLOQUEADO.

Configuration
REQ-035 With CAJERO_DESBLOQUEO_EN defined, BLOQUEADO SHALL exit to IDLE after TIMEOUT_CYCLES cycles, clearing BLOQUEO and fail counter; without it, only reset leaves BLOQUEADO.

Verification
REQ-036 N_DIGITS=4, PIN_CORRECTO=16'h2098, digits 2,0,9,8, deposit MONTO=500, BALANCE_INICIAL=1000 -> BALANCE_STB one pulse, BALANCE_ACTUALIZADO=1500.
REQ-037 Correct PIN, withdraw 300 from 1000 -> BALANCE_ACTUALIZADO=700, BALANCE_STB and ENTREGAR_DINERO same cycle.
REQ-038 Correct PIN, withdraw 1200 from 1000 -> FONDOS_INSUFICIENTES one pulse, no BALANCE_STB, no ENTREGAR_DINERO.
REQ-039 Wrong PIN 1,1,1,1 three times -> PIN_INCORRECTO x3, ADVERTENCIA after second, BLOQUEO=1 after third; further DIGITO_STB no effect.
REQ-040 BAL_W=8, deposit 10 onto 250 -> BALANCE_ACTUALIZADO=255; reset asserted during PIN entry -> IDLE, outputs 0.
REQ-041 With CAJERO_DESBLOQUEO_EN, TIMEOUT_CYCLES=20, after lockout -> BLOQUEO falls 20 cycles later; without macro, BLOQUEO still 1 after 100 cycles.
